// File: rtl/spi_ms.sv
// Mode-0, LSB-first SPI master: frames cmd_tx with chip-select setup/hold/idle timing and captures MISO.
// Optional build macro SPI_MS_LOOPBACK_EN: RX samples the outgoing MOSI instead of spi_miso.
module spi_ms #(
  parameter int TRANSF_SIZE = 32,
  parameter int CLK_DIV     = 4,
  parameter int CS_SETUP    = 2,
  parameter int CS_HOLD     = 8,
  parameter int CS_IDLE     = 4
) (
  input  logic                   sclk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [TRANSF_SIZE-1:0] cmd_tx,
  output logic                   busy,
  output logic                   done,
  output logic [TRANSF_SIZE-1:0] rx_data,
  output logic                   spi_sck,
  output logic                   spi_cs_n,
  output logic                   spi_mosi,
  input  logic                   spi_miso
);

  localparam int MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B   = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;
  localparam int BIT_W   = $clog2(TRANSF_SIZE) + 1;

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [BIT_W-1:0]       bit_reg, bit_next;
  logic                   sck_reg, sck_next;
  logic                   cs_n_reg, cs_n_next;
  logic                   mosi_reg, mosi_next;
  logic                   busy_reg, busy_next;
  logic                   done_reg, done_next;
  logic [TRANSF_SIZE-1:0] tx_reg, tx_next;
  logic [TRANSF_SIZE-1:0] rx_reg, rx_next;
  logic [TRANSF_SIZE-1:0] rx_data_reg, rx_data_next;
  logic                   rx_bit;

`ifdef SPI_MS_LOOPBACK_EN
  assign rx_bit = mosi_reg;
`else
  assign rx_bit = spi_miso;
`endif

  always_ff @(posedge sclk) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      sck_reg     <= 1'b0;
      cs_n_reg    <= 1'b1;
      mosi_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      tx_reg      <= '0;
      rx_reg      <= '0;
      rx_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_reg     <= bit_next;
      sck_reg     <= sck_next;
      cs_n_reg    <= cs_n_next;
      mosi_reg    <= mosi_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      tx_reg      <= tx_next;
      rx_reg      <= rx_next;
      rx_data_reg <= rx_data_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_next     = bit_reg;
    sck_next     = sck_reg;
    cs_n_next    = cs_n_reg;
    mosi_next    = mosi_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    tx_next      = tx_reg;
    rx_next      = rx_reg;
    rx_data_next = rx_data_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          tx_next    = cmd_tx;
          rx_next    = '0;
          cs_n_next  = 1'b0;
          mosi_next  = cmd_tx[0];
          busy_next  = 1'b1;
          cnt_next   = '0;
          bit_next   = '0;
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (cnt_reg == CNT_W'(CS_SETUP - 1)) begin
          cnt_next   = '0;
          state_next = XFER;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      XFER: begin
        if (cnt_reg == CNT_W'(CLK_DIV - 1)) begin
          cnt_next = '0;
          sck_next = ~sck_reg;
          if (!sck_reg) begin
            bit_next = bit_reg + 1'b1;
          end else begin
            // Falling edge: capture MISO and advance MOSI; the shifted-in zeros leave MOSI low after the last bit.
            rx_next   = {rx_bit, rx_reg[TRANSF_SIZE-1:1]};
            tx_next   = {1'b0, tx_reg[TRANSF_SIZE-1:1]};
            mosi_next = tx_reg[1];
            if (bit_reg == BIT_W'(TRANSF_SIZE)) begin
              state_next = HOLD;
            end
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_reg == CNT_W'(CS_HOLD - 1)) begin
          cnt_next     = '0;
          cs_n_next    = 1'b1;
          done_next    = 1'b1;
          rx_data_next = rx_reg;
          state_next   = GAP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      GAP: begin
        if (cnt_reg == CNT_W'(CS_IDLE - 1)) begin
          cnt_next   = '0;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign rx_data  = rx_data_reg;
  assign spi_sck  = sck_reg;
  assign spi_cs_n = cs_n_reg;
  assign spi_mosi = mosi_reg;

endmodule

// File: tb/tb_spi_ms.sv
// Directed bench for spi_ms with default parameters: frame timing, MOSI content, MISO capture, busy and reset behaviour.
module tb_spi_ms;
  logic        sclk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cmd_tx = '0;
  logic        busy, done, spi_sck, spi_cs_n, spi_mosi;
  logic        spi_miso = 1'b0;
  logic [31:0] rx_data;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] miso_frame = '0;
  int miso_idx = 0;
  logic [31:0] last_rx = '0;

  spi_ms dut (
    .sclk(sclk), .rstn(rstn), .start(start), .cmd_tx(cmd_tx),
    .busy(busy), .done(done), .rx_data(rx_data),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 sclk = ~sclk;

  // Slave model: presents the next response bit on each SCK rise, LSB first.
  always @(posedge spi_sck or posedge spi_cs_n) begin
    if (spi_cs_n) begin
      miso_idx = 0;
      spi_miso = 1'b0;
    end else if (miso_idx < 32) begin
      spi_miso = miso_frame[miso_idx];
      miso_idx++;
    end
  end

  typedef struct {
    string       name;
    logic [31:0] cmd;
    logic [31:0] mframe;
    logic [31:0] exp_rx;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_frame(input string name, input logic [31:0] cmd, input logic [31:0] mframe,
                           input logic [31:0] exp_rx, input int pulse_at, input bit hold_start);
    int rises, first_rise, done_at, done_cnt, fall_at;
    logic [31:0] mosi_word;
    logic prev_sck, hold_ok;
    miso_frame = mframe;
    @(negedge sclk);
    cmd_tx = cmd;
    start  = 1'b1;
    @(posedge sclk); #1;
    if (!hold_start) start = 1'b0;
    check({name, " cs_fall"}, {31'b0, spi_cs_n}, 32'd0);
    rises = 0; first_rise = -1; done_at = -1; done_cnt = 0; fall_at = -1;
    mosi_word = '0; prev_sck = 1'b0; hold_ok = 1'b1;
    for (int n = 1; n <= 1000; n++) begin
      @(posedge sclk); #1;
      if (pulse_at == n) start = 1'b1;
      else if (!hold_start) start = 1'b0;
      if (spi_sck && !prev_sck) begin
        if (rises < 32) mosi_word[rises] = spi_mosi;
        rises++;
        if (first_rise < 0) first_rise = n;
      end
      prev_sck = spi_sck;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (done_at < 0 && rx_data !== last_rx) hold_ok = 1'b0;
      if (!busy) begin
        fall_at = n;
        break;
      end
    end
    check({name, " sck_rises"}, 32'(rises), 32'd32);
    check({name, " mosi_word"}, mosi_word, cmd);
    check({name, " first_rise"}, 32'(first_rise), 32'd6);
    check({name, " done_at"}, 32'(done_at), 32'd266);
    check({name, " done_count"}, 32'(done_cnt), 32'd1);
    check({name, " busy_fall"}, 32'(fall_at), 32'd270);
    check({name, " rx_held"}, {31'b0, hold_ok}, 32'd1);
    check({name, " rx_data"}, rx_data, exp_rx);
    check({name, " idle_lines"}, {29'b0, spi_cs_n, spi_sck, spi_mosi}, 32'b100);
    last_rx = exp_rx;
  endtask

  function automatic logic [31:0] expect_rx(input logic [31:0] cmd, input logic [31:0] mframe);
`ifdef SPI_MS_LOOPBACK_EN
    return cmd;
`else
    return mframe;
`endif
  endfunction

  vec_t vecs[5];

  initial begin
    int rises;
    logic prev_sck, ok;
    vecs[0] = '{"write_abc", 32'h0ABC0500, 32'h00000000, 32'h0};
    vecs[1] = '{"read_a5",   32'h00000501, 32'h00000ABC, 32'h0};
    vecs[2] = '{"all_ones",  32'hFFFFFFFF, 32'h80000001, 32'h0};
    vecs[3] = '{"zeros",     32'h00000000, 32'hDEADBEEF, 32'h0};
`ifdef SPI_MS_LOOPBACK_EN
    vecs[4] = '{"loopback",  32'hDEADBEEF, 32'h00000000, 32'h0};
`else
    vecs[4] = '{"alt_bits",  32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0};
`endif
    for (int i = 0; i < 5; i++) vecs[i].exp_rx = expect_rx(vecs[i].cmd, vecs[i].mframe);

    // Reset with start asserted
    rstn = 1'b0; start = 1'b1;
    repeat (3) @(posedge sclk);
    #1;
    check("reset outputs", {27'b0, spi_cs_n, spi_sck, spi_mosi, busy, done}, 32'b10000);
    check("reset rx_data", rx_data, 32'h0);
    @(negedge sclk);
    start = 1'b0; rstn = 1'b1;
    repeat (2) @(posedge sclk);

    // Reset after the 10th SCK rise aborts the frame
    @(negedge sclk);
    cmd_tx = 32'h0ABC0500; miso_frame = 32'hFFFFFFFF; start = 1'b1;
    @(posedge sclk); #1;
    start = 1'b0;
    rises = 0; prev_sck = 1'b0;
    for (int n = 0; n < 200 && rises < 10; n++) begin
      @(posedge sclk); #1;
      if (spi_sck && !prev_sck) rises++;
      prev_sck = spi_sck;
    end
    check("abort reached 10 rises", 32'(rises), 32'd10);
    rstn = 1'b0;
    @(posedge sclk); #1;
    check("abort outputs", {27'b0, spi_cs_n, spi_sck, spi_mosi, busy, done}, 32'b10000);
    rstn = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      @(posedge sclk); #1;
      if (done || rx_data !== 32'h0 || !spi_cs_n) ok = 1'b0;
    end
    check("abort no done", {31'b0, ok}, 32'd1);
    run_frame("after_abort", 32'h0ABC0500, 32'h00000000, expect_rx(32'h0ABC0500, 32'h0), 0, 1'b0);

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].name, vecs[i].cmd, vecs[i].mframe, vecs[i].exp_rx, 0, 1'b0);
      $display("frame %s cmd=0x%08h rx=0x%08h", vecs[i].name, vecs[i].cmd, rx_data);
    end

    // Mid-frame start pulse must not queue a second frame
    run_frame("busy_pulse", 32'h12345678, 32'h0000F00D, expect_rx(32'h12345678, 32'h0000F00D), 50, 1'b0);
    ok = 1'b1;
    repeat (20) begin
      @(posedge sclk); #1;
      if (busy || !spi_cs_n) ok = 1'b0;
    end
    check("busy_pulse ignored", {31'b0, ok}, 32'd1);

    // Start held high: back-to-back frames with one idle cycle
    run_frame("held_start", 32'h0ABC0500, 32'h00000ABC, expect_rx(32'h0ABC0500, 32'h00000ABC), 0, 1'b1);
    @(posedge sclk); #1;
    check("held busy low one cycle", {31'b0, busy}, 32'd1);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(posedge sclk); #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("held second done", {31'b0, ok}, 32'd1);
    check("held second rx", rx_data, expect_rx(32'h0ABC0500, 32'h00000ABC));
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge sclk); #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("held busy release", {31'b0, ok}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
